// File: rtl/actor_write_receiver_if.sv
// Actor-write drain bus between the CGRA write stream and the
// actor parameter interconnect.
interface actor_write_receiver_if #(
  parameter int ACTOR_ID_WIDTH = 4,
  parameter int DATA_WIDTH     = 32
);
  logic                      EN_I;
  logic [ACTOR_ID_WIDTH-1:0] ACTOR_WRITE_ADDR_I;
  logic [DATA_WIDTH-1:0]     ACTOR_DATA_I;
  logic                      ACTOR_WRITE_ENABLE_I;
  logic                      SYNC_IN_I;
  logic                      ACTOR_VALID_O;
  logic                      ACTOR_READY_I;
  logic [ACTOR_ID_WIDTH-1:0] ACTOR_ID_O;
  logic [DATA_WIDTH-1:0]     ACTOR_DATA_O;
  logic                      ACTOR_LAST_O;
  logic                      BUSY_O;
  logic                      OVERRUN_O;
  logic                      OVERRUN_CLR_I;

  modport slave (
    input  EN_I, ACTOR_WRITE_ADDR_I, ACTOR_DATA_I,
    input  ACTOR_WRITE_ENABLE_I, SYNC_IN_I,
    input  ACTOR_READY_I, OVERRUN_CLR_I,
    output ACTOR_VALID_O, ACTOR_ID_O, ACTOR_DATA_O,
    output ACTOR_LAST_O, BUSY_O, OVERRUN_O
  );

  modport master (
    output EN_I, ACTOR_WRITE_ADDR_I, ACTOR_DATA_I,
    output ACTOR_WRITE_ENABLE_I, SYNC_IN_I,
    output ACTOR_READY_I, OVERRUN_CLR_I,
    input  ACTOR_VALID_O, ACTOR_ID_O, ACTOR_DATA_O,
    input  ACTOR_LAST_O, BUSY_O, OVERRUN_O
  );
endinterface

// File: rtl/actor_write_receiver.sv
// Shadow/commit actor bank: writes gather in shadow, a sync commits
// the dirty slots and drains them lowest-index first over valid/ready.
module actor_write_receiver #(
  parameter int ACTOR_ID_WIDTH = 4,
  parameter int NUM_ACTORS     = 16,
  parameter int DATA_WIDTH     = 32
) (
  input logic CGRA_CLK_I,
  input logic RST_N_I,
  actor_write_receiver_if.slave bus
);

  typedef enum logic {IDLE, DRAIN} state_t;

  typedef logic [ACTOR_ID_WIDTH-1:0] id_t;
  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [NUM_ACTORS-1:0]     mask_t;

  state_t state;
  word_t  shadow_q [NUM_ACTORS];
  word_t  commit_q [NUM_ACTORS];
  word_t  shadow_d [NUM_ACTORS];
  word_t  commit_d [NUM_ACTORS];
  mask_t  dirty_q;
  mask_t  pend_q;
  mask_t  dirty_d;
  mask_t  pend_d;
  mask_t  wr_hit;
  mask_t  done_hit;
  logic   sync_go;
  logic   hs;
  logic   one_left;
  id_t    sel_id;
  word_t  sel_data;
  logic   valid_q;
  id_t    id_q;
  word_t  data_q;
  logic   last_q;
  logic   ovr_q;

  // Next bank/mask contents; next presented word is chosen from them
  // so the outputs can be registered without a ready-to-output path.
  always_comb begin
    sync_go  = bus.EN_I & bus.SYNC_IN_I & (state == IDLE);
    hs       = valid_q & bus.ACTOR_READY_I;
    wr_hit   = '0;
    done_hit = '0;
    for (int i = 0; i < NUM_ACTORS; i++) begin
      wr_hit[i]   = bus.EN_I & bus.ACTOR_WRITE_ENABLE_I &
                    (bus.ACTOR_WRITE_ADDR_I == id_t'(i));
      done_hit[i] = hs & (id_q == id_t'(i));
      shadow_d[i] = wr_hit[i] ? bus.ACTOR_DATA_I : shadow_q[i];
      commit_d[i] = sync_go ? shadow_d[i] : commit_q[i];
    end
    dirty_d = sync_go ? '0 : (dirty_q | wr_hit);
    pend_d  = sync_go ? (dirty_q | wr_hit) : (pend_q & ~done_hit);
    sel_id   = '0;
    sel_data = '0;
    for (int i = NUM_ACTORS - 1; i >= 0; i--) begin
      if (pend_d[i]) begin
        sel_id   = id_t'(i);
        sel_data = commit_d[i];
      end
    end
    one_left = (pend_d != '0) &&
               ((pend_d & (pend_d - mask_t'(1))) == '0);
  end

  // Drain FSM with banks, masks and registered outputs.
  always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state   <= IDLE;
      dirty_q <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_ACTORS; i++) begin
        shadow_q[i] <= '0;
        commit_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ACTORS; i++) begin
        shadow_q[i] <= shadow_d[i];
        commit_q[i] <= commit_d[i];
      end
      dirty_q <= dirty_d;
      pend_q  <= pend_d;
      state   <= (pend_d != '0) ? DRAIN : IDLE;
      valid_q <= (pend_d != '0);
      id_q    <= sel_id;
      data_q  <= sel_data;
      last_q  <= one_left;
      if (bus.OVERRUN_CLR_I)
        ovr_q <= 1'b0;
      else if (bus.EN_I & bus.SYNC_IN_I & (state == DRAIN))
        ovr_q <= 1'b1;
    end
  end

  assign bus.ACTOR_VALID_O = valid_q;
  assign bus.ACTOR_ID_O    = id_q;
  assign bus.ACTOR_DATA_O  = data_q;
  assign bus.ACTOR_LAST_O  = last_q;
  assign bus.BUSY_O        = (state == DRAIN);
  assign bus.OVERRUN_O     = ovr_q;

endmodule

// File: tb/tb_actor_write_receiver.sv
// Bench for actor_write_receiver: queue-based drain model checked
// every cycle, plus literal drain logs for the directed scenarios.
module tb_actor_write_receiver;

  localparam int IW = 4;
  localparam int NA = 12;
  localparam int DW = 32;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  actor_write_receiver_if #(.ACTOR_ID_WIDTH(IW), .DATA_WIDTH(DW)) bus();

  actor_write_receiver #(
    .ACTOR_ID_WIDTH(IW),
    .NUM_ACTORS(NA),
    .DATA_WIDTH(DW)
  ) dut (
    .CGRA_CLK_I(clk),
    .RST_N_I(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: pending commit is a queue of words in ascending slot order.
  word_t       m_q[$];
  logic [31:0] m_shadow [NA];
  bit          m_dirty [NA];
  bit          m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovr = 1'b0;
      for (int i = 0; i < NA; i++) begin
        m_shadow[i] = '0;
        m_dirty[i]  = 1'b0;
      end
    end else begin
      automatic bit busy_pre = (m_q.size() > 0);
      automatic int a = int'(bus.ACTOR_WRITE_ADDR_I);
      if (busy_pre && bus.ACTOR_READY_I) void'(m_q.pop_front());
      if (bus.EN_I && bus.ACTOR_WRITE_ENABLE_I && a < NA) begin
        m_shadow[a] = bus.ACTOR_DATA_I;
        m_dirty[a]  = 1'b1;
      end
      if (bus.OVERRUN_CLR_I) m_ovr = 1'b0;
      else if (bus.EN_I && bus.SYNC_IN_I && busy_pre) m_ovr = 1'b1;
      if (bus.EN_I && bus.SYNC_IN_I && !busy_pre) begin
        for (int i = 0; i < NA; i++) begin
          if (m_dirty[i]) begin
            automatic word_t w;
            w.id   = i;
            w.data = m_shadow[i];
            w.last = 1'b0;
            m_q.push_back(w);
          end
          m_dirty[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit mv = (m_q.size() > 0);
      chk("valid", 32'(bus.ACTOR_VALID_O), 32'(mv));
      chk("busy", 32'(bus.BUSY_O), 32'(mv));
      chk("overrun", 32'(bus.OVERRUN_O), 32'(m_ovr));
      if (mv) begin
        chk("id", 32'(bus.ACTOR_ID_O), 32'(m_q[0].id));
        chk("data", bus.ACTOR_DATA_O, m_q[0].data);
        chk("last", 32'(bus.ACTOR_LAST_O), 32'(m_q.size() == 1));
      end
    end
  end

  // Log of handshakes seen on the DUT outputs.
  word_t hlog[$];
  always @(negedge clk) begin
    if (rst_n && bus.ACTOR_VALID_O && bus.ACTOR_READY_I) begin
      automatic word_t w;
      w.id   = int'(bus.ACTOR_ID_O);
      w.data = bus.ACTOR_DATA_O;
      w.last = bus.ACTOR_LAST_O;
      hlog.push_back(w);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.ACTOR_WRITE_ADDR_I   = IW'(a);
    bus.ACTOR_DATA_I         = d;
    bus.ACTOR_WRITE_ENABLE_I = 1'b1;
    cyc();
    bus.ACTOR_WRITE_ENABLE_I = 1'b0;
  endtask

  task automatic sync();
    bus.SYNC_IN_I = 1'b1;
    cyc();
    bus.SYNC_IN_I = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (bus.BUSY_O && n < 40) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic chk_log(string name, int n, int id0, logic [31:0] d0,
                         int id1, logic [31:0] d1,
                         int id2, logic [31:0] d2);
    int ids [3];
    logic [31:0] ds [3];
    ids = '{id0, id1, id2};
    ds  = '{d0, d1, d2};
    chk({name, "_count"}, 32'(hlog.size()), 32'(n));
    for (int i = 0; i < n && i < hlog.size(); i++) begin
      chk({name, "_id"}, 32'(hlog[i].id), 32'(ids[i]));
      chk({name, "_data"}, hlog[i].data, ds[i]);
      chk({name, "_last"}, 32'(hlog[i].last), 32'(i == n - 1));
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus.EN_I                 = 1'b1;
    bus.ACTOR_WRITE_ADDR_I   = '0;
    bus.ACTOR_DATA_I         = '0;
    bus.ACTOR_WRITE_ENABLE_I = 1'b0;
    bus.SYNC_IN_I            = 1'b0;
    bus.ACTOR_READY_I        = 1'b1;
    bus.OVERRUN_CLR_I        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst_valid", 32'(bus.ACTOR_VALID_O), 32'd0);
    chk("rst_busy", 32'(bus.BUSY_O), 32'd0);
    chk("rst_ovr", 32'(bus.OVERRUN_O), 32'd0);
    chk("rst_id", 32'(bus.ACTOR_ID_O), 32'd0);
    chk("rst_data", bus.ACTOR_DATA_O, 32'd0);

    // Three-slot commit, full throughput.
    wr(5, 32'hA5);
    wr(2, 32'h22);
    wr(9, 32'h99);
    hlog.delete();
    sync();
    chk("t1_valid_first", 32'(bus.ACTOR_VALID_O), 32'd1);
    chk("t1_id_first", 32'(bus.ACTOR_ID_O), 32'd2);
    drain();
    chk_log("t1", 3, 2, 32'h22, 5, 32'hA5, 9, 32'h99);

    // Same commit under backpressure.
    bus.ACTOR_READY_I = 1'b0;
    wr(5, 32'hA5);
    wr(2, 32'h22);
    wr(9, 32'h99);
    hlog.delete();
    sync();
    repeat (4) cyc();
    chk("t2_hold_id", 32'(bus.ACTOR_ID_O), 32'd2);
    for (int n = 0; n < 40 && bus.BUSY_O; n++) begin
      bus.ACTOR_READY_I = ~bus.ACTOR_READY_I;
      cyc();
    end
    chk("t2_idle", 32'(bus.BUSY_O), 32'd0);
    chk_log("t2", 3, 2, 32'h22, 5, 32'hA5, 9, 32'h99);
    bus.ACTOR_READY_I = 1'b1;

    // Write bypassed into a same-cycle sync; then an empty sync.
    hlog.delete();
    bus.ACTOR_WRITE_ADDR_I   = 4'd3;
    bus.ACTOR_DATA_I         = 32'h1234;
    bus.ACTOR_WRITE_ENABLE_I = 1'b1;
    bus.SYNC_IN_I            = 1'b1;
    cyc();
    bus.ACTOR_WRITE_ENABLE_I = 1'b0;
    bus.SYNC_IN_I            = 1'b0;
    drain();
    chk_log("t3", 1, 3, 32'h1234, 0, 0, 0, 0);
    hlog.delete();
    sync();
    chk("t3_empty_valid", 32'(bus.ACTOR_VALID_O), 32'd0);
    repeat (3) cyc();
    chk("t3_empty_log", 32'(hlog.size()), 32'd0);

    // Overrun while busy; carried write drains on next sync.
    bus.ACTOR_READY_I = 1'b0;
    wr(1, 32'h11);
    wr(4, 32'h44);
    hlog.delete();
    sync();
    wr(7, 32'h77);
    sync();
    chk("t4_ovr_set", 32'(bus.OVERRUN_O), 32'd1);
    bus.ACTOR_READY_I = 1'b1;
    drain();
    chk_log("t4a", 2, 1, 32'h11, 4, 32'h44, 0, 0);
    hlog.delete();
    sync();
    drain();
    chk_log("t4b", 1, 7, 32'h77, 0, 0, 0, 0);
    bus.OVERRUN_CLR_I = 1'b1;
    cyc();
    bus.OVERRUN_CLR_I = 1'b0;
    chk("t4_ovr_clr", 32'(bus.OVERRUN_O), 32'd0);
    bus.ACTOR_READY_I = 1'b0;
    wr(0, 32'h5);
    sync();
    bus.SYNC_IN_I     = 1'b1;
    bus.OVERRUN_CLR_I = 1'b1;
    cyc();
    bus.SYNC_IN_I     = 1'b0;
    bus.OVERRUN_CLR_I = 1'b0;
    chk("t4_clr_wins", 32'(bus.OVERRUN_O), 32'd0);
    bus.ACTOR_READY_I = 1'b1;
    drain();

    // Out-of-range address and EN_I=0 write/sync.
    hlog.delete();
    wr(15, 32'hDEAD);
    bus.EN_I = 1'b0;
    wr(2, 32'hBEEF);
    sync();
    chk("t5_en0_valid", 32'(bus.ACTOR_VALID_O), 32'd0);
    bus.EN_I = 1'b1;
    sync();
    repeat (3) cyc();
    chk("t5_no_drain", 32'(hlog.size()), 32'd0);

    // Asynchronous reset in the middle of a drain.
    bus.ACTOR_READY_I = 1'b0;
    wr(6, 32'h66);
    wr(8, 32'h88);
    sync();
    cyc();
    chk("t6_pre_valid", 32'(bus.ACTOR_VALID_O), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.ACTOR_VALID_O), 32'd0);
    chk("t6_rst_busy", 32'(bus.BUSY_O), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ACTOR_READY_I = 1'b1;
    cyc();
    hlog.delete();
    sync();
    repeat (3) cyc();
    chk("t6_no_drain", 32'(hlog.size()), 32'd0);
    chk("t6_idle", 32'(bus.BUSY_O), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/actor_write_receiver.md
Name: actor_write_receiver

Overview:
- Actor-side receiver for the CGRA actor-write stream: per-context actor address, selected PE data, write enable and sync marker.
- Writes collect in a shadow bank. On sync, the dirty entries are committed atomically and drained, one per cycle, to the actor interconnect over a valid/ready handshake.
- Sits between the CGRA PE-data mux and the actor parameter interconnect.

Parameters:
- ACTOR_ID_WIDTH, 4, width of actor address and ACTOR_ID_O.
- NUM_ACTORS, 16, number of implemented actor slots (≤ 2^ACTOR_ID_WIDTH).
- DATA_WIDTH, 32, actor data word width.

Ports:
- CGRA_CLK_I  in  1  single clock.
- RST_N_I  in  1  reset, asynchronous, active-low.
- EN_I  in  1  input-side enable; gates write and sync sampling only.
- ACTOR_WRITE_ADDR_I  in  ACTOR_ID_WIDTH  target actor slot.
- ACTOR_DATA_I  in  DATA_WIDTH  data from the selected source PE.
- ACTOR_WRITE_ENABLE_I  in  1  write strobe.
- SYNC_IN_I  in  1  commit marker.
- ACTOR_VALID_O  out  1  drain word valid.
- ACTOR_READY_I  in  1  interconnect ready.
- ACTOR_ID_O  out  ACTOR_ID_WIDTH  slot of the presented word.
- ACTOR_DATA_O  out  DATA_WIDTH  committed data of the presented word.
- ACTOR_LAST_O  out  1  presented word is the final one of this commit.
- BUSY_O  out  1  drain FSM not IDLE.
- OVERRUN_O  out  1  sticky: a sync arrived while busy.
- OVERRUN_CLR_I  in  1  clears OVERRUN_O.

Behaviour:
- Reset (async, RST_N_I=0):
  - shadow bank, commit bank, dirty mask and pending mask all 0;
  - FSM to IDLE;
  - all outputs 0.
- Write: when EN_I & ACTOR_WRITE_ENABLE_I & addr<NUM_ACTORS, then shadow[addr]<=data and dirty[addr]<=1 at the clock edge.
  - addr≥NUM_ACTORS: write silently dropped.
  - Writes are accepted in every FSM state.
- Sync in IDLE (EN_I & SYNC_IN_I):
  - commit<=shadow and pending<=dirty; dirty<=0.
  - A write in the same cycle is bypassed into both commit and pending; it does not remain dirty.
  - Any pending bit set: go to DRAIN, and VALID asserts the next cycle (latency 1).
  - Mask empty: stay IDLE; no output activity.
- Sync while BUSY_O=1: ignored. OVERRUN_O<=1; shadow and dirty untouched, so they carry into the next sync. A same-cycle write still lands in shadow.
- DRAIN:
  - presents the lowest-index pending slot: ID=index, DATA=commit[index].
  - LAST_O=1 iff exactly one pending bit remains.
  - On VALID&READY: clear that pending bit. The next slot is presented the following cycle (throughput 1 word/cycle, VALID stays high).
  - After the LAST handshake: VALID<=0 and go to IDLE; BUSY_O drops the same cycle as VALID.
- Handshake rules: once VALID is high, ID/DATA/LAST stay stable until READY. VALID never drops without a handshake.
- Output-side activity and the pending mask are independent of EN_I. EN_I=0 only blocks capture of writes and syncs.
- OVERRUN_CLR_I has priority over a same-cycle overrun set; the clear wins.
- Reset mid-drain: the remaining pending words are lost and VALID drops immediately (asynchronous).
- Outputs are registered; there are no combinational paths from ACTOR_READY_I to any output.

Test Plan:
- Commit of three slots: write slots 5, 2, 9 with 0xA5, 0x22, 0x99, then sync, READY=1.
  - Expect VALID from sync+1 for 3 consecutive cycles.
  - Expect IDs 2, 5, 9 with matching data; LAST only on ID 9; BUSY then low.
- Backpressure: same commit, READY held low for 4 cycles, then toggled.
  - ID/DATA/LAST hold stable while READY is low.
  - Exactly 3 handshakes occur; no word is duplicated or skipped.
- Same-cycle write and sync: write slot 3=0x1234 together with sync.
  - Slot 3 is drained with 0x1234, LAST=1.
  - A following empty sync produces no VALID.
- Overrun: commit 2 slots with READY=0, write slot 7=0x77, pulse sync while busy.
  - OVERRUN_O=1 and the drain is unchanged (2 words).
  - The next sync in IDLE drains slot 7.
  - OVERRUN_CLR_I clears the flag.
- Boundaries: write addr 15 with NUM_ACTORS=12, plus EN_I=0 write and sync.
  - No dirty bit set, no drain.
  - Separately, async reset mid-drain: VALID=0 immediately, and a later sync with no writes produces no output.
